// File: rtl/fp_to_linear_decoder.sv
// Serial decoder: expands {sign, exp, sig} float words into OUT_W-bit two's-complement samples.
// Optional macro FP_DEC_MIDPOINT_EN reconstructs the midpoint of each quantization interval.
module fp_to_linear_decoder #(
    parameter int unsigned EXP_W = 3,
    parameter int unsigned SIG_W = 4,
    parameter int unsigned OUT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [SIG_W-1:0] in_sig,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
);

    localparam int unsigned MAG_W = OUT_W - 1;
    localparam logic [EXP_W-1:0] ExpOne = {{(EXP_W-1){1'b0}}, 1'b1};

    if (OUT_W < SIG_W + (1 << EXP_W)) begin : g_bad_cfg
        $fatal(1, "fp_to_linear_decoder: OUT_W too small for SIG_W and EXP_W");
    end

    typedef enum logic [1:0] {StIdle, StShift, StSign, StOut} state_e;

    state_e             state_q, state_d;
    logic [MAG_W-1:0]   mag_q, mag_d;
    logic [EXP_W-1:0]   cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic [MAG_W-1:0]   mag_fin;
`ifdef FP_DEC_MIDPOINT_EN
    logic [EXP_W-1:0]   exp_q, exp_d;
`endif

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Magnitude presented to the sign stage; midpoint build adds half an LSB step.
    always_comb begin
        mag_fin = mag_q;
`ifdef FP_DEC_MIDPOINT_EN
        if (exp_q != '0) begin
            mag_fin = mag_q + ({{(MAG_W-1){1'b0}}, 1'b1} << (exp_q - ExpOne));
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        mag_d       = mag_q;
        cnt_d       = cnt_q;
        sign_d      = sign_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
`ifdef FP_DEC_MIDPOINT_EN
        exp_d       = exp_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    mag_d   = {{(MAG_W-SIG_W){1'b0}}, in_sig};
                    cnt_d   = in_exp;
`ifdef FP_DEC_MIDPOINT_EN
                    exp_d   = in_exp;
`endif
                    state_d = (in_exp != '0) ? StShift : StSign;
                end
            end
            StShift: begin
                mag_d = mag_q << 1;
                cnt_d = cnt_q - ExpOne;
                if (cnt_q == ExpOne) begin
                    state_d = StSign;
                end
            end
            StSign: begin
                // Negating zero yields zero, so no negative-zero special case is needed.
                out_data_d  = sign_q ? (~{1'b0, mag_fin} + OUT_W'(1)) : {1'b0, mag_fin};
                out_valid_d = 1'b1;
                state_d     = StOut;
            end
            StOut: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mag_q       <= '0;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
`ifdef FP_DEC_MIDPOINT_EN
            exp_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            cnt_q       <= cnt_d;
            sign_q      <= sign_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
`ifdef FP_DEC_MIDPOINT_EN
            exp_q       <= exp_d;
`endif
        end
    end

endmodule

// File: tb/tb_fp_to_linear_decoder.sv
// Directed bench for fp_to_linear_decoder; expected values follow FP_DEC_MIDPOINT_EN if defined.
module tb_fp_to_linear_decoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [2:0]  in_exp;
    logic [3:0]  in_sig;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;

    int total = 0;
    int bad   = 0;

    fp_to_linear_decoder #(
        .EXP_W(3),
        .SIG_W(4),
        .OUT_W(12)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sign  (in_sign),
        .in_exp   (in_exp),
        .in_sig   (in_sig),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Present one word, count edges (including the accepting edge) until out_valid, check result.
    task automatic decode(input string tag, input logic s, input logic [2:0] e,
                          input logic [3:0] m, input logic [11:0] expv);
        int n;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_sign  = s;
        in_exp   = e;
        in_sig   = m;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sign  = ~s;
        in_exp   = ~e;
        in_sig   = ~m;
        n = 1;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(e) + 32'd2);
        check({tag, "_data"}, 32'(out_data), 32'(expv));
        if (out_ready) begin
            @(posedge clk); #1;
            check({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
            check({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
        end
    endtask

    logic [11:0] held;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_sig    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef FP_DEC_MIDPOINT_EN
        decode("p0e0s5", 1'b0, 3'd0, 4'd5, 12'h005);
        decode("p0e7s15", 1'b0, 3'd7, 4'd15, 12'h7C0);
        decode("n1e3s9", 1'b1, 3'd3, 4'd9, 12'hFB4);
        decode("n1e4s0", 1'b1, 3'd4, 4'd0, 12'hFF8);
        decode("p0e1s1", 1'b0, 3'd1, 4'd1, 12'h003);
        decode("n1e0s1", 1'b1, 3'd0, 4'd1, 12'hFFF);
        decode("n1e7s15", 1'b1, 3'd7, 4'd15, 12'h840);
`else
        decode("p0e0s5", 1'b0, 3'd0, 4'd5, 12'h005);
        decode("p0e7s15", 1'b0, 3'd7, 4'd15, 12'h780);
        decode("n1e3s9", 1'b1, 3'd3, 4'd9, 12'hFB8);
        decode("n1e4s0", 1'b1, 3'd4, 4'd0, 12'h000);
        decode("p0e1s1", 1'b0, 3'd1, 4'd1, 12'h002);
        decode("n1e0s1", 1'b1, 3'd0, 4'd1, 12'hFFF);
        decode("n1e7s15", 1'b1, 3'd7, 4'd15, 12'h880);
`endif

        // Back-pressure: result must hold while out_ready is low; new input ignored.
        out_ready = 1'b0;
`ifdef FP_DEC_MIDPOINT_EN
        held = 12'h00E;
`else
        held = 12'h00C;
`endif
        decode("stall", 1'b0, 3'd2, 4'd3, held);
        in_valid = 1'b1;
        in_sign  = 1'b1;
        in_exp   = 3'd5;
        in_sig   = 4'd7;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'(held));
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_release_valid", 32'(out_valid), 32'd0);
        check("stall_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        check("stall_single_hs", 32'(out_valid), 32'd0);
        decode("after_stall", 1'b0, 3'd0, 4'd7, 12'h007);

        // Reset mid-shift aborts the word.
        in_sign  = 1'b0;
        in_exp   = 3'd6;
        in_sig   = 4'd1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_shift_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_data", 32'(out_data), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("post_rst_no_valid", 32'(out_valid), 32'd0);
        end
`ifdef FP_DEC_MIDPOINT_EN
        decode("post_rst", 1'b1, 3'd2, 4'd6, 12'hFE6);
`else
        decode("post_rst", 1'b1, 3'd2, 4'd6, 12'hFE8);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
